// File: rtl/wrap_pkg.sv
// Shared types for the core-wrapper boundary chain: wrapper mode encoding.
package wrap_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    FUNC   = 2'd0,
    INTEST = 2'd1,
    EXTEST = 2'd2,
    SAFE   = 2'd3
  } wrap_mode_e;

endpackage

// File: rtl/wrap_boundary_chain_if.sv
// TDR control, serial test path and functional buses of the wrapper boundary chain.
interface wrap_boundary_chain_if #(
  parameter int NUM_IN  = 3,
  parameter int NUM_OUT = 3
) ();
  import wrap_pkg::*;

  localparam int CW = $clog2(NUM_IN + NUM_OUT + 2);

  logic               TDR_CAPTURE;
  logic               TDR_SHIFT;
  logic               TDR_UPDATE;
  logic               WRAP_TDR_EN;
  logic [MODE_W-1:0]  wrap_mode;
  logic               CTI;
  logic               CTO;
  logic [NUM_IN-1:0]  core_func_in;
  logic [NUM_IN-1:0]  func_in_core;
  logic [NUM_OUT-1:0] core_func_out;
  logic [NUM_OUT-1:0] func_out_pad;
  logic [CW-1:0]      shift_cnt;
  logic               len_err;

  modport master (
    output TDR_CAPTURE, TDR_SHIFT, TDR_UPDATE, WRAP_TDR_EN, wrap_mode, CTI,
           core_func_in, core_func_out,
    input  CTO, func_in_core, func_out_pad, shift_cnt, len_err
  );

  modport slave (
    input  TDR_CAPTURE, TDR_SHIFT, TDR_UPDATE, WRAP_TDR_EN, wrap_mode, CTI,
           core_func_in, core_func_out,
    output CTO, func_in_core, func_out_pad, shift_cnt, len_err
  );

endinterface

// File: rtl/wrap_cell.sv
// One boundary bit: shift flop with capture/shift mux and an update flop.
module wrap_cell #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_capture,
  input  logic i_shift,
  input  logic i_update,
  input  logic i_cap_d,
  input  logic i_ser_d,
  output logic o_sr,
  output logic o_upd
);

  logic r_sr;
  logic r_upd;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sr  <= 1'b0;
      r_upd <= RST_VAL;
    end else if (i_en) begin
      // capture wins over shift; update always sees the pre-edge shift value
      if (i_capture)    r_sr <= i_cap_d;
      else if (i_shift) r_sr <= i_ser_d;
      if (i_update)     r_upd <= r_sr;
    end
  end

  assign o_sr  = r_sr;
  assign o_upd = r_upd;

endmodule

// File: rtl/wrap_boundary_chain.sv
// Parametrised wrapper boundary register: NUM_IN input + NUM_OUT output cells, mode, bypass, length check.
// Define WRAP_SAFE_MODE_EN to enable SAFE mode; otherwise mode 3 latches as FUNC.
module wrap_boundary_chain
  import wrap_pkg::*;
#(
  parameter int                 NUM_IN   = 3,
  parameter int                 NUM_OUT  = 3,
  parameter logic [NUM_IN-1:0]  SAFE_IN  = '1,
  parameter logic [NUM_OUT-1:0] SAFE_OUT = '1
) (
  input logic                  TDR_TCK,
  input logic                  TDR_TRESET,
  wrap_boundary_chain_if.slave bus
);

  localparam int L  = NUM_IN + NUM_OUT;
  localparam int CW = $clog2(NUM_IN + NUM_OUT + 2);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_LEN = CW'(L);
  localparam logic [L-1:0]  UPD_RST = {SAFE_OUT, SAFE_IN};

  logic [L-1:0]  w_cap_d;
  logic [L-1:0]  w_ser_d;
  logic [L-1:0]  w_sr;
  logic [L-1:0]  w_upd;
  wrap_mode_e    w_mode_next;
  wrap_mode_e    r_mode;
  logic [CW-1:0] r_cnt;
  logic          r_len_err;
  logic          r_bypass;

  assign w_cap_d = {bus.core_func_out, bus.core_func_in};
  assign w_ser_d = {w_sr[L-2:0], bus.CTI};

  genvar gi;
  generate
    for (gi = 0; gi < L; gi++) begin : g_cell
      wrap_cell #(.RST_VAL(UPD_RST[gi])) u_cell (
        .i_clk     (TDR_TCK),
        .i_rst     (TDR_TRESET),
        .i_en      (bus.WRAP_TDR_EN),
        .i_capture (bus.TDR_CAPTURE),
        .i_shift   (bus.TDR_SHIFT),
        .i_update  (bus.TDR_UPDATE),
        .i_cap_d   (w_cap_d[gi]),
        .i_ser_d   (w_ser_d[gi]),
        .o_sr      (w_sr[gi]),
        .o_upd     (w_upd[gi])
      );
    end
  endgenerate

`ifdef WRAP_SAFE_MODE_EN
  assign w_mode_next = wrap_mode_e'(bus.wrap_mode);
`else
  assign w_mode_next = (wrap_mode_e'(bus.wrap_mode) == SAFE) ? FUNC : wrap_mode_e'(bus.wrap_mode);
`endif

  always_ff @(posedge TDR_TCK or posedge TDR_TRESET) begin
    if (TDR_TRESET) begin
      r_mode    <= FUNC;
      r_cnt     <= '0;
      r_len_err <= 1'b0;
      r_bypass  <= 1'b0;
    end else if (bus.WRAP_TDR_EN) begin
      if (bus.TDR_CAPTURE)                     r_cnt <= '0;
      else if (bus.TDR_SHIFT && r_cnt != CNT_MAX) r_cnt <= r_cnt + CW'(1);
      if (bus.TDR_UPDATE) begin
        r_mode <= w_mode_next;
        if (r_cnt != CNT_LEN) r_len_err <= 1'b1;
      end
    end else if (bus.TDR_SHIFT) begin
      r_bypass <= bus.CTI;
    end
  end

  // both sources are flops, so CTO has no combinational path from CTI
  assign bus.CTO       = bus.WRAP_TDR_EN ? w_sr[L-1] : r_bypass;
  assign bus.shift_cnt = r_cnt;
  assign bus.len_err   = r_len_err;

  always_comb begin
    bus.func_in_core = bus.core_func_in;
    bus.func_out_pad = bus.core_func_out;
    case (r_mode)
      INTEST: bus.func_in_core = w_upd[NUM_IN-1:0];
      EXTEST: bus.func_out_pad = w_upd[L-1:NUM_IN];
`ifdef WRAP_SAFE_MODE_EN
      SAFE: begin
        bus.func_in_core = SAFE_IN;
        bus.func_out_pad = SAFE_OUT;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wrap_boundary_chain.sv
// Directed self-checking bench for wrap_boundary_chain (NUM_IN=3, NUM_OUT=3).
module tb_wrap_boundary_chain;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  wrap_boundary_chain_if #(.NUM_IN(3), .NUM_OUT(3)) bus ();

  wrap_boundary_chain #(.NUM_IN(3), .NUM_OUT(3)) dut (
    .TDR_TCK    (clk),
    .TDR_TRESET (rst),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_capture(input logic [2:0] fin, input logic [2:0] fout);
    bus.core_func_in  = fin;
    bus.core_func_out = fout;
    bus.TDR_CAPTURE   = 1'b1;
    tick();
    bus.TDR_CAPTURE   = 1'b0;
  endtask

  task automatic do_shift(input logic b);
    bus.CTI       = b;
    bus.TDR_SHIFT = 1'b1;
    tick();
    bus.TDR_SHIFT = 1'b0;
  endtask

  task automatic do_update(input logic [1:0] m);
    bus.wrap_mode  = m;
    bus.TDR_UPDATE = 1'b1;
    tick();
    bus.TDR_UPDATE = 1'b0;
  endtask

  int exp_cto[6] = '{0, 1, 1, 1, 1, 0};
  logic [5:0] pat;

  initial begin
    rst = 1'b1;
    bus.TDR_CAPTURE   = 1'b0;
    bus.TDR_SHIFT     = 1'b0;
    bus.TDR_UPDATE    = 1'b0;
    bus.WRAP_TDR_EN   = 1'b1;
    bus.wrap_mode     = 2'd0;
    bus.CTI           = 1'b0;
    bus.core_func_in  = 3'b101;
    bus.core_func_out = 3'b010;
    #12;
    check_eq("rst_func_in",  bus.func_in_core, 3'b101);
    check_eq("rst_func_out", bus.func_out_pad, 3'b010);
    check_eq("rst_cto",      bus.CTO, 0);
    check_eq("rst_cnt",      bus.shift_cnt, 0);
    check_eq("rst_len_err",  bus.len_err, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // capture and unload: out[2..0] then in[2..0]
    do_capture(3'b110, 3'b011);
    check_eq("cap_cnt", bus.shift_cnt, 0);
    check_eq("unload_0", bus.CTO, exp_cto[0]);
    for (int i = 1; i < 6; i++) begin
      do_shift(1'b0);
      check_eq($sformatf("unload_%0d", i), bus.CTO, exp_cto[i]);
    end
    check_eq("unload_cnt5", bus.shift_cnt, 5);

    // EXTEST: out cells 101, in cells 000
    do_capture(3'b110, 3'b011);
    pat = 6'b101000;
    for (int i = 5; i >= 0; i--) do_shift(pat[i]);
    check_eq("ext_cnt", bus.shift_cnt, 6);
    do_update(2'd2);
    check_eq("ext_func_out", bus.func_out_pad, 3'b101);
    check_eq("ext_func_in",  bus.func_in_core, 3'b110);
    check_eq("ext_len_err",  bus.len_err, 0);

    // INTEST: in cells 011
    do_capture(3'b110, 3'b011);
    pat = 6'b000011;
    for (int i = 5; i >= 0; i--) do_shift(pat[i]);
    do_update(2'd1);
    check_eq("int_func_in",  bus.func_in_core, 3'b011);
    check_eq("int_func_out", bus.func_out_pad, 3'b011);

    // capture wins over a simultaneous shift
    bus.TDR_SHIFT = 1'b1;
    do_capture(3'b110, 3'b100);
    check_eq("prio_cnt", bus.shift_cnt, 0);
    check_eq("prio_cto", bus.CTO, 1);

    // short chain: 5 shifts then update
    for (int i = 0; i < 5; i++) do_shift(1'b0);
    do_update(2'd0);
    check_eq("short_len_err", bus.len_err, 1);
    check_eq("func_back_in",  bus.func_in_core, 3'b110);
    check_eq("func_back_out", bus.func_out_pad, 3'b100);
    do_capture(3'b110, 3'b100);
    for (int i = 0; i < 6; i++) do_shift(1'b0);
    do_update(2'd0);
    check_eq("sticky_len_err", bus.len_err, 1);
    check_eq("sticky_cnt",     bus.shift_cnt, 6);

    // bypass: 1-edge delay, chain state holds
    bus.WRAP_TDR_EN = 1'b0;
    pat = 6'b000101;
    for (int i = 2; i >= 0; i--) begin
      do_shift(pat[i]);
      check_eq($sformatf("byp_cto_%0d", 2 - i), bus.CTO, pat[i]);
    end
    do_capture(3'b111, 3'b111);
    do_update(2'd2);
    check_eq("byp_cnt",      bus.shift_cnt, 6);
    check_eq("byp_func_out", bus.func_out_pad, 3'b111);
    bus.WRAP_TDR_EN = 1'b1;
    #1;
    check_eq("byp_sr_hold", bus.CTO, 0);

    // safe mode request
    do_capture(3'b010, 3'b100);
    for (int i = 0; i < 6; i++) do_shift(1'b0);
    do_update(2'd3);
`ifdef WRAP_SAFE_MODE_EN
    check_eq("safe_in",  bus.func_in_core, 3'b111);
    check_eq("safe_out", bus.func_out_pad, 3'b111);
`else
    check_eq("safe_in",  bus.func_in_core, 3'b010);
    check_eq("safe_out", bus.func_out_pad, 3'b100);
`endif

    // asynchronous reset mid-shift
    do_capture(3'b010, 3'b111);
    for (int i = 0; i < 3; i++) do_shift(1'b1);
    rst = 1'b1;
    #2;
    check_eq("arst_cnt",     bus.shift_cnt, 0);
    check_eq("arst_len_err", bus.len_err, 0);
    check_eq("arst_cto",     bus.CTO, 0);
    check_eq("arst_func_in", bus.func_in_core, 3'b010);
    rst = 1'b0;
    tick();
    do_capture(3'b010, 3'b111);
    for (int i = 0; i < 6; i++) do_shift(1'b0);
    do_update(2'd0);
    check_eq("post_rst_len_err", bus.len_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wrap_boundary_chain.md
# wrap_boundary_chain

Parametrised core-wrapper boundary register: NUM_IN input cells and NUM_OUT output cells in one serial chain, driven by the TDR capture/shift/update strobes on the test clock. It replaces hand-instantiated, fixed-count wrapper cells with a single block. The block adds:
- a registered wrapper mode (functional / intest / extest / safe);
- a bypass bit;
- a shift counter with a chain-length error flag.

It sits between the physical interface and the core, under the TAP's TDR control.

## Interface
- NUM_IN, default 3: number of input cells (pin→core), ≥1
- NUM_OUT, default 3: number of output cells (core→pin), ≥1
- SAFE_IN, default all ones (NUM_IN bits): value driven to the core in safe mode
- SAFE_OUT, default all ones (NUM_OUT bits): value driven to the pins in safe mode
- TDR_TCK  in  1  test clock; all state on its rising edge
- TDR_TRESET  in  1  asynchronous, active-high reset
- TDR_CAPTURE  in  1  capture strobe
- TDR_SHIFT  in  1  shift strobe
- TDR_UPDATE  in  1  update strobe
- WRAP_TDR_EN  in  1  chain selected; when low, CTI→CTO goes through the 1-bit bypass
- wrap_mode  in  2  requested mode (0 FUNC, 1 INTEST, 2 EXTEST, 3 SAFE)
- CTI  in  1  serial test input
- CTO  out  1  serial test output
- core_func_in  in  NUM_IN  functional inputs from pins
- func_in_core  out  NUM_IN  inputs delivered to the core
- core_func_out  in  NUM_OUT  functional outputs from the core
- func_out_pad  out  NUM_OUT  outputs delivered to the pins
- shift_cnt  out  CW  shift cycles since the last capture, saturating; CW = $clog2(NUM_IN+NUM_OUT+2)
- len_err  out  1  sticky flag: an update was seen with a wrong shift count

## Operation
- Chain order is CTI → in[0..NUM_IN-1] → out[0..NUM_OUT-1] → CTO. L = NUM_IN+NUM_OUT.
- WRAP_TDR_EN high:
  - CAPTURE: in cells load core_func_in, out cells load core_func_out; shift_cnt clears to 0.
  - SHIFT: sr[0]←CTI, sr[i]←sr[i-1]; shift_cnt increments and saturates at 2^CW−1.
  - UPDATE: the update registers load sr; mode_q←wrap_mode; if shift_cnt≠L then len_err←1.
- Strobe priority: CAPTURE over SHIFT when both are high. UPDATE may coincide with either and uses the pre-edge sr and shift_cnt.
- WRAP_TDR_EN low:
  - The bypass flop loads CTI on SHIFT.
  - sr, update registers, mode_q, shift_cnt and len_err all hold.
- CTO = sr[L-1] when WRAP_TDR_EN is high, otherwise the bypass flop. It is a flop output with no combinational path from CTI.
- func_in_core by mode_q:
  - INTEST: upd_in
  - SAFE: SAFE_IN
  - otherwise: core_func_in
- func_out_pad by mode_q:
  - EXTEST: upd_out
  - SAFE: SAFE_OUT
  - otherwise: core_func_out
- Functional paths are combinational: zero-cycle latency from the functional input to the delivered output.
- len_err is cleared only by reset.

## Timing
- Reset values:
  - sr=0, bypass=0, CTO=0
  - upd_in=SAFE_IN, upd_out=SAFE_OUT
  - mode_q=FUNC, so the outputs pass through immediately
  - shift_cnt=0, len_err=0
- A reset asserted mid-shift clears everything asynchronously. The next update after reset still requires exactly L shifts following a capture.
- Shift latency is L TDR_TCK edges from CTI to CTO when enabled, and 1 edge in bypass.
- Mode and data change on the same UPDATE edge, so there are no mixed-mode glitch cycles.

## Configuration
- WRAP_SAFE_MODE_EN defined: SAFE mode (3) behaves as described above.
- WRAP_SAFE_MODE_EN undefined:
  - wrap_mode=3 latches as FUNC.
  - SAFE_IN and SAFE_OUT are used only as the update-register reset values.

## Structure
- Shared package wrap_pkg holds the wrap_mode_e enum (FUNC, INTEST, EXTEST, SAFE) and the mode width constant.
- Sub-module wrap_cell is one bit: shift flop with capture/shift mux plus an update flop with a parametrised reset value. wrap_boundary_chain instantiates it L times via generate.

## Test plan
- Reset, NUM_IN=3, NUM_OUT=3, mode FUNC:
  - core_func_in=3'b101 → func_in_core=3'b101, CTO=0, shift_cnt=0, len_err=0.
- Capture then shift, with core_func_in=3'b110, core_func_out=3'b011:
  - CAPTURE, then 6 SHIFTs with CTI=0 → CTO sequence is out[2..0], then in[2..0], i.e. 0,1,1,1,1,0.
- EXTEST load:
  - Shift 6'b101_000 (out cells hold 101), then UPDATE with wrap_mode=2 → func_out_pad=3'b101 on that edge; shift_cnt=6; len_err stays 0.
- Length error:
  - CAPTURE, 5 SHIFTs, UPDATE → len_err=1, and stays 1 after a later correct 6-shift update.
- Bypass:
  - WRAP_TDR_EN=0, CTI pattern 1,0,1 over 3 SHIFTs → CTO is the pattern delayed by 1 edge.
  - sr and shift_cnt do not change.
- Safe mode:
  - With WRAP_SAFE_MODE_EN, UPDATE with wrap_mode=3 → func_in_core=3'b111, func_out_pad=3'b111.
  - Without the macro, the same UPDATE → functional pass-through.
